div_seq: RTL and testbench

//  Multi-cycle sequencer for DIV/DIVU. Sits beside EX: EX issues start with both operands; block

---
 rtl/div_seq.sv | 128 ++++++++++++
 tb/tb_div_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle radix-2 shift-subtract DIV/DIVU sequencer
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             neg_quot;
    logic             neg_rem;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Magnitudes are only taken for signed operands with the sign bit set
    assign a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign b_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // The dividend register doubles as the quotient register as bits shift out
    assign shifted = {rem, dvd[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs};
    assign rem_nx  = ge ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];

    assign quot_fix = neg_quot ? (~dvd + 1'b1) : dvd;
    assign rem_fix  = neg_rem  ? (~rem + 1'b1) : rem;

    assign ready_o    = (state == S_END);
    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start_i && !annul_i)
                    state_nx = (opdata2_i == '0) ? S_BYZERO : S_ON;
            end
            S_BYZERO: state_nx = annul_i ? S_IDLE : S_END;
            S_ON: begin
                if (annul_i)
                    state_nx = S_IDLE;
                else if (cnt == CNT_LAST)
                    state_nx = S_END;
            end
            S_END: begin
                if (annul_i || !start_i)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        cnt      <= '0;
                        dvd      <= a_abs;
                        dvs      <= b_abs;
                        rem      <= '0;
                        neg_quot <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem  <= signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
                S_BYZERO: begin
                    if (!annul_i)
                        result_o <= '0;
                end
                S_ON: begin
                    if (!annul_i) begin
                        if (cnt == CNT_LAST) begin
                            result_o <= {rem_fix, quot_fix};
                        end else begin
                            rem <= rem_nx;
                            dvd <= {dvd[WIDTH-2:0], ge};
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - randomized self-checking bench for div_seq against an arithmetic model
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int checks   = 0;
    int failures = 0;
    logic [63:0] last_exp;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stallreq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: truncating division, remainder follows dividend, x/0 gives zeros
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        bit stall_ok;
        logic [63:0] exp;
        exp = model(s, a, b);
        @(negedge clk);
        signed_div = s;
        op1 = a;
        op2 = b;
        start = 1'b1;
        #1;
        check({tag, ".stall0"}, stallreq, 1'b1);
        n = 0;
        stall_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                op1 = $urandom;
                op2 = $urandom;
                signed_div = $urandom;
            end
            if (!ready && !stallreq) stall_ok = 1'b0;
        end while (!ready && n < 100);
        check({tag, ".lat"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd34);
        check({tag, ".stall"}, 64'(stall_ok), 64'd1);
        check({tag, ".result"}, result, exp);
        check({tag, ".stall_rdy"}, stallreq, 1'b0);
        start = 1'b0;
        last_exp = exp;
        @(negedge clk);
        check({tag, ".rdy_drop"}, ready, 1'b0);
        check({tag, ".hold"}, result, exp);
    endtask

    initial begin
        bit rose;
        rst = 1'b0;
        signed_div = 1'b0;
        op1 = '0;
        op2 = '0;
        start = 1'b0;
        annul = 1'b0;
        last_exp = '0;
        repeat (3) @(negedge clk);
        check("rst.result", result, 64'd0);
        check("rst.ready", ready, 1'b0);
        check("rst.stall", stallreq, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        check("divu_100_7.exp", last_exp, {32'd2, 32'd14});
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        do_div(1'b0, 32'd5, 32'd0, "divu_by0");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd0, "div_by0");

        // Annul mid-divide: no ready, previous result retained
        @(negedge clk);
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        #1;
        check("annul.stall", stallreq, 1'b0);
        @(negedge clk);
        annul = 1'b0;
        rose = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) rose = 1'b1;
        end
        check("annul.no_ready", 64'(rose), 64'd0);
        check("annul.keep", result, last_exp);
        do_div(1'b0, 32'd1000, 32'd3, "divu_1000_3");

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        signed_div = 1'b0;
        op1 = 32'd12345;
        op2 = 32'd11;
        start = 1'b1;
        repeat (15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst.result", result, 64'd0);
        check("arst.ready", ready, 1'b0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("arst.ready_hold", ready, 1'b0);
        rst = 1'b1;
        do_div(1'b0, 32'd9, 32'd3, "divu_9_3");

        for (int i = 0; i < 14; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit s;
            s = $urandom;
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -($urandom_range(1, 15));
                3: b = a + 32'd1;
                default: b = $urandom;
            endcase
            if (i % 4 == 0) a = $urandom_range(0, 50);
            do_div(s, a, b, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
